// File: rtl/neuron_pkg.sv
// Shared types and widths for the neuron sequencer block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuron_pkg;

    // Width of activations, weights and the neuron result.
    localparam int DATA_W = 8;
    // Width of one full signed din*w product.
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        ACTIVATE = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_act.sv
// Activation stage: saturates the shifted accumulator to signed 8 bits,
// optionally clamping negatives to zero when NEURON_SEQ_RELU_EN is defined.
// Latency: combinational. Backpressure: none.
// Ports: shifted (ACC_W signed in), act_out (DATA_W signed out).
module neuron_act
    import neuron_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0]  shifted,
    output logic signed [DATA_W-1:0] act_out
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

    always_comb begin
        act_out = shifted[DATA_W-1:0];
`ifdef NEURON_SEQ_RELU_EN
        if (shifted < 0) begin
            act_out = '0;
        end else if (shifted > SAT_MAX) begin
            act_out = 8'sd127;
        end
`else
        if (shifted > SAT_MAX) begin
            act_out = 8'sd127;
        end else if (shifted < SAT_MIN) begin
            act_out = -8'sd128;
        end
`endif
    end

endmodule

// File: rtl/neuron_sequencer.sv
// Neuron evaluation sequencer: on start, accumulates N_INPUTS signed din*w
// products, shifts right by SHIFT, applies activation and holds the result.
// Latency: result valid 2 cycles after the last accepted beat.
// Backpressure: din_ready only in ACCUM; result held until out_ready.
// Ports: clk, rst (sync, active-high), start, din_valid/din_ready/din/w,
// out_valid/out_ready/out, busy. Build option: NEURON_SEQ_RELU_EN.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20,
    parameter int SHIFT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [DATA_W-1:0] din,
    input  logic signed [DATA_W-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     busy
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  out_q, out_d;
    logic                      din_ready_q, out_valid_q, busy_q;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  act_out;

    assign prod    = din * w;
    assign shifted = acc_q >>> SHIFT;

    neuron_act #(
        .ACC_W (ACC_W)
    ) u_act (
        .shifted (shifted),
        .act_out (act_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (din_valid && din_ready_q) begin
                    acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                        state_d = ACTIVATE;
                    end
                end
            end
            ACTIVATE: begin
                out_d   = act_out;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            din_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            din_ready_q <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign din_ready = din_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: directed and randomized
// evaluations compared against an integer reference of the neuron rule.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_neuron_sequencer;

    localparam int N     = 4;
    localparam int ACC_W = 20;
    localparam int SHIFT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              din_valid;
    logic              din_ready;
    logic signed [7:0] din;
    logic signed [7:0] w;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out;
    logic              busy;

    always #5 clk = ~clk;

    neuron_sequencer #(
        .N_INPUTS (N),
        .ACC_W    (ACC_W),
        .SHIFT    (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic signed [7:0] pd[N];
    logic signed [7:0] pw[N];
    bit                pat[7];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: dot product, floor division by 2^SHIFT, then activation.
    function automatic int model();
        int s = 0;
        for (int k = 0; k < N; k++) begin
            s += int'(pd[k]) * int'(pw[k]);
        end
        s = s >>> SHIFT;
`ifdef NEURON_SEQ_RELU_EN
        if (s < 0) s = 0;
        if (s > 127) s = 127;
`else
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        return s;
    endfunction

    task automatic fill(input int d, input int wt);
        for (int k = 0; k < N; k++) begin
            pd[k] = 8'(d);
            pw[k] = 8'(wt);
        end
    endtask

    // mode 0: din_valid always 1; 1: fixed pattern; 2: random bubbles.
    task automatic run_eval(input int mode, input int hold);
        int  exp;
        int  beats;
        int  cyc;
        bit  v;
        exp   = model();
        beats = 0;
        cyc   = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_accum", int'(busy), 1);
        check("rdy_accum", int'(din_ready), 1);
        while (beats < N && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc < 7) ? pat[cyc] : 1'b1;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            din_valid = v;
            din       = v ? pd[beats] : 8'($urandom);
            w         = v ? pw[beats] : 8'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (v) beats++;
            cyc++;
            if (beats < N) begin
                check("rdy_in_accum", int'(din_ready), 1);
                check("vld_in_accum", int'(out_valid), 0);
            end
        end
        din_valid = 1'b0;
        start     = 1'b0;
        check("act_rdy", int'(din_ready), 0);
        check("act_vld", int'(out_valid), 0);
        check("act_busy", int'(busy), 1);
        @(negedge clk);
        check("done_vld", int'(out_valid), 1);
        check("done_out", int'(out), exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            check("hold_vld", int'(out_valid), 1);
            check("hold_out", int'(out), exp);
            check("hold_busy", int'(busy), 1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_vld", int'(out_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_out", int'(out), exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst       = 1'b1;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        w         = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_vld", int'(out_valid), 0);
        check("rst_rdy", int'(din_ready), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        fill(10, 20);
        check("model_basic", model(), 50);
        run_eval(0, 0);

        fill(127, 127);
        run_eval(0, 1);

        fill(-100, 100);
        run_eval(0, 0);

        fill(10, 20);
        run_eval(1, 2);

        fill(10, 20);
        run_eval(0, 5);

        // Reset in the middle of accumulation, with every other input active.
        fill(127, 127);
        run_eval(0, 0);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        din_valid = 1'b1;
        din       = 8'sd10;
        w         = 8'sd20;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_vld", int'(out_valid), 0);
        check("mid_rst_rdy", int'(din_ready), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst       = 1'b0;
        start     = 1'b0;
        din_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        fill(10, 20);
        run_eval(0, 0);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < N; k++) begin
                pd[k] = 8'($urandom);
                pw[k] = 8'($urandom);
            end
            run_eval(2, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
